// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-index constants, arbiter source select and
// the legal-destination rule for register file writes.
package regfile_write_arbiter_pkg;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] word_t;

   localparam reg_idx_t REG_ZERO = 5'd0;
   localparam reg_idx_t REG_K0   = 5'd26;
   localparam reg_idx_t REG_K1   = 5'd27;
   localparam reg_idx_t REG_SP   = 5'd29;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_PW,
      SRC_FIFO,
      SRC_BYP
   } src_t;

   function automatic logic legal_dest(input reg_idx_t d);
      return !(d == REG_ZERO || d == REG_K0 || d == REG_K1);
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_ll_result_fifo.sv
// Long-latency result FIFO with per-entry valid bits, parallel
// squash by destination and a first-live-entry head view.
module ll_result_fifo
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  reg_idx_t    push_dest,
   input  word_t       push_data,
   input  logic        pop,
   input  logic        squash_en,
   input  reg_idx_t    squash_dest,
   output logic        full,
   output logic        head_valid,
   output reg_idx_t    head_dest,
   output word_t       head_data,
   output logic [31:0] pending
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   reg_idx_t         dest_q [DEPTH];
   word_t            data_q [DEPTH];
   logic [DEPTH-1:0] vld;

   logic [PW-1:0] rd_ptr, wr_ptr, count;
   logic [PW-1:0] head_off, skip;
   logic [AW-1:0] rd_idx, wr_idx, head_idx, scan_idx;

   assign rd_idx   = rd_ptr[AW-1:0];
   assign wr_idx   = wr_ptr[AW-1:0];
   assign count    = wr_ptr - rd_ptr;
   assign full     = (rd_ptr[AW] != wr_ptr[AW]) && (rd_idx == wr_idx);
   assign head_idx = rd_idx + head_off[AW-1:0];

   // Head is the oldest live entry; squashed ones ahead of it are skipped.
   always_comb begin
      head_valid = 1'b0;
      head_off   = '0;
      scan_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rd_idx + AW'(i);
         if (!head_valid && PW'(i) < count && vld[scan_idx]) begin
            head_valid = 1'b1;
            head_off   = PW'(i);
         end
      end
   end

   assign head_dest = dest_q[head_idx];
   assign head_data = data_q[head_idx];

   always_comb begin
      skip = '0;
      if (pop)
         skip = head_off + PW'(1);
      else if (head_valid)
         skip = head_off;
      else
         skip = count;
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++)
         if (vld[i])
            pending[dest_q[i]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         vld    <= '0;
      end else begin
         rd_ptr <= rd_ptr + skip;
         for (int i = 0; i < DEPTH; i++)
            if (PW'(i) < skip)
               vld[rd_idx + AW'(i)] <= 1'b0;
         for (int j = 0; j < DEPTH; j++)
            if (squash_en && vld[j] && dest_q[j] == squash_dest)
               vld[j] <= 1'b0;
         if (push) begin
            vld[wr_idx] <= 1'b1;
            wr_ptr      <= wr_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         dest_q[wr_idx] <= push_dest;
         data_q[wr_idx] <= push_data;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: pipeline writeback first, then
// buffered long-latency results, with starvation relief via Stall.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int LL_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        WB_Valid,
   input  logic        WB_RegWrite,
   input  logic        WB_MemToReg,
   input  logic [4:0]  WB_Dest,
   input  logic [31:0] WB_ALUResult,
   input  logic [31:0] WB_MemData,
   input  logic        LL_Valid,
   input  logic [4:0]  LL_Dest,
   input  logic [31:0] LL_Data,
   output logic        LL_Ready,
   output logic [4:0]  WAddr,
   output logic [31:0] WData,
   output logic        RegWrite,
   output logic [31:0] Pending,
   output logic        Stall
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic     pw, ll_legal, bypass, fifo_issue, push, full;
   logic     head_valid;
   reg_idx_t head_dest;
   word_t    head_data, wb_data;
   src_t     src;

   logic [CW-1:0] starve_cnt, starve_inc;

   assign pw       = WB_Valid & WB_RegWrite & legal_dest(WB_Dest);
   assign wb_data  = WB_MemToReg ? WB_MemData : WB_ALUResult;
   assign ll_legal = legal_dest(LL_Dest);
   assign LL_Ready = !full;

   assign fifo_issue = !pw & head_valid;
   assign bypass     = !pw & !head_valid & LL_Valid & ll_legal & LL_Ready;
   // A result racing a younger pipeline write to the same reg is dead.
   assign push = LL_Valid & LL_Ready & ll_legal & !bypass &
                 !(pw && LL_Dest == WB_Dest);

   always_comb begin
      src = SRC_NONE;
      if (pw)
         src = SRC_PW;
      else if (fifo_issue)
         src = SRC_FIFO;
      else if (bypass)
         src = SRC_BYP;
   end

   ll_result_fifo #(
      .DEPTH(LL_DEPTH)
   ) u_fifo (
      .clk        (Clk),
      .rst        (Rst),
      .push       (push),
      .push_dest  (LL_Dest),
      .push_data  (LL_Data),
      .pop        (fifo_issue),
      .squash_en  (pw),
      .squash_dest(WB_Dest),
      .full       (full),
      .head_valid (head_valid),
      .head_dest  (head_dest),
      .head_data  (head_data),
      .pending    (Pending)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         RegWrite <= 1'b0;
         WAddr    <= '0;
         WData    <= '0;
      end else begin
         unique case (src)
            SRC_PW: begin
               RegWrite <= 1'b1;
               WAddr    <= WB_Dest;
               WData    <= wb_data;
            end
            SRC_FIFO: begin
               RegWrite <= 1'b1;
               WAddr    <= head_dest;
               WData    <= head_data;
            end
            SRC_BYP: begin
               RegWrite <= 1'b1;
               WAddr    <= LL_Dest;
               WData    <= LL_Data;
            end
            SRC_NONE: RegWrite <= 1'b0;
         endcase
      end
   end

   assign starve_inc = starve_cnt + CW'(1);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         starve_cnt <= '0;
         Stall      <= 1'b0;
      end else begin
         Stall <= 1'b0;
         if (fifo_issue || !head_valid) begin
            starve_cnt <= '0;
         end else if (starve_inc == LIMIT) begin
            starve_cnt <= '0;
            Stall      <= 1'b1;
         end else begin
            starve_cnt <= starve_inc;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: queue-based reference
// model checked every cycle, plus hand-computed literal checks.
module tb_regfile_write_arbiter;

   localparam int DEPTH  = 2;
   localparam int STARVE = 4;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        WB_Valid, WB_RegWrite, WB_MemToReg;
   logic [4:0]  WB_Dest;
   logic [31:0] WB_ALUResult, WB_MemData;
   logic        LL_Valid;
   logic [4:0]  LL_Dest;
   logic [31:0] LL_Data;
   logic        LL_Ready;
   logic [4:0]  WAddr;
   logic [31:0] WData;
   logic        RegWrite;
   logic [31:0] Pending;
   logic        Stall;

   int total = 0;
   int bad   = 0;

   regfile_write_arbiter #(
      .LL_DEPTH    (DEPTH),
      .STARVE_LIMIT(STARVE)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .WB_Valid    (WB_Valid),
      .WB_RegWrite (WB_RegWrite),
      .WB_MemToReg (WB_MemToReg),
      .WB_Dest     (WB_Dest),
      .WB_ALUResult(WB_ALUResult),
      .WB_MemData  (WB_MemData),
      .LL_Valid    (LL_Valid),
      .LL_Dest     (LL_Dest),
      .LL_Data     (LL_Data),
      .LL_Ready    (LL_Ready),
      .WAddr       (WAddr),
      .WData       (WData),
      .RegWrite    (RegWrite),
      .Pending     (Pending),
      .Stall       (Stall)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: ordered list of buffered results, dead once squashed.
   typedef struct {
      logic [4:0]  d;
      logic [31:0] v;
      bit          live;
   } ent_t;

   ent_t        q[$];
   bit          started = 0;
   logic        m_rw = 0;
   logic [4:0]  m_wa = 0;
   logic [31:0] m_wd = 0;
   logic        m_stall = 0;
   int          m_cnt = 0;

   function automatic bit ok(input logic [4:0] d);
      return d != 0 && d != 26 && d != 27;
   endfunction

   function automatic logic [31:0] m_pend();
      logic [31:0] p = 0;
      foreach (q[i])
         if (q[i].live)
            p[q[i].d] = 1'b1;
      return p;
   endfunction

   always @(posedge Clk) begin
      bit pw, rdy, byp, fiss, enq;
      int h;
      if (Rst) begin
         started = 1;
         q.delete();
         m_rw = 0; m_wa = 0; m_wd = 0;
         m_stall = 0; m_cnt = 0;
      end else if (started) begin
         pw  = WB_Valid && WB_RegWrite && ok(WB_Dest);
         rdy = q.size() < DEPTH;
         h = -1;
         foreach (q[i])
            if (h < 0 && q[i].live)
               h = i;
         fiss = !pw && h >= 0;
         byp  = !pw && h < 0 && LL_Valid && ok(LL_Dest) && rdy;
         enq  = LL_Valid && rdy && ok(LL_Dest) && !byp &&
                !(pw && LL_Dest == WB_Dest);
         m_stall = 0;
         if (fiss || h < 0) begin
            m_cnt = 0;
         end else if (pw) begin
            m_cnt++;
            if (m_cnt == STARVE) begin
               m_cnt = 0;
               m_stall = 1;
            end
         end
         if (pw) begin
            m_rw = 1; m_wa = WB_Dest;
            m_wd = WB_MemToReg ? WB_MemData : WB_ALUResult;
         end else if (fiss) begin
            m_rw = 1; m_wa = q[h].d; m_wd = q[h].v;
         end else if (byp) begin
            m_rw = 1; m_wa = LL_Dest; m_wd = LL_Data;
         end else begin
            m_rw = 0;
         end
         if (h < 0)
            q.delete();
         else
            repeat (fiss ? h + 1 : h) void'(q.pop_front());
         if (pw)
            foreach (q[i])
               if (q[i].d == WB_Dest)
                  q[i].live = 0;
         if (enq)
            q.push_back('{LL_Dest, LL_Data, 1'b1});
      end
   end

   always @(negedge Clk) begin
      if (started) begin
         chk("regwrite", {31'd0, RegWrite}, {31'd0, m_rw});
         chk("waddr", {27'd0, WAddr}, {27'd0, m_wa});
         chk("wdata", WData, m_wd);
         chk("pending", Pending, m_pend());
         chk("ll_ready", {31'd0, LL_Ready},
             {31'd0, q.size() < DEPTH});
         chk("stall", {31'd0, Stall}, {31'd0, m_stall});
         if (Stall)
            chk("stall_wb_valid", {31'd0, WB_Valid}, 32'd0);
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      WB_Valid = 0; WB_RegWrite = 0; WB_MemToReg = 0;
      WB_Dest = 0; WB_ALUResult = 0; WB_MemData = 0;
      LL_Valid = 0; LL_Dest = 0; LL_Data = 0;
   endtask

   task automatic pw(input logic [4:0] d, input logic [31:0] alu,
                     input logic [31:0] mem, input logic m2r);
      WB_Valid = 1; WB_RegWrite = 1; WB_MemToReg = m2r;
      WB_Dest = d; WB_ALUResult = alu; WB_MemData = mem;
   endtask

   task automatic ll(input logic [4:0] d, input logic [31:0] v);
      LL_Valid = 1; LL_Dest = d; LL_Data = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      Rst = 1;
      ll(5'd9, 32'h1111_1111);
      tick();
      tick();
      Rst = 0;
      idle();
      chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("rst_pending", Pending, 32'd0);
      chk("rst_ll_ready", {31'd0, LL_Ready}, 32'd1);
      chk("rst_waddr", {27'd0, WAddr}, 32'd0);

      pw(5'd8, 32'h0000_00AB, 32'h0000_1234, 1'b0);
      tick();
      chk("pw_regwrite", {31'd0, RegWrite}, 32'd1);
      chk("pw_waddr", {27'd0, WAddr}, 32'd8);
      chk("pw_wdata", WData, 32'h0000_00AB);
      pw(5'd3, 32'h0000_00CD, 32'h8000_0001, 1'b1);
      tick();
      chk("pw_mem_wdata", WData, 32'h8000_0001);
      for (int i = 0; i < 3; i++) begin
         logic [4:0] bad_d [3];
         bad_d = '{5'd0, 5'd26, 5'd27};
         pw(bad_d[i], 32'h7777_7777, 32'h0, 1'b0);
         tick();
         chk("illegal_pw_regwrite", {31'd0, RegWrite}, 32'd0);
         chk("illegal_pw_waddr_hold", {27'd0, WAddr}, 32'd3);
      end

      idle();
      ll(5'd9, 32'hFFFF_FFFB);
      tick();
      chk("byp_waddr", {27'd0, WAddr}, 32'd9);
      chk("byp_wdata", WData, 32'hFFFF_FFFB);
      chk("byp_pending", Pending, 32'd0);
      ll(5'd27, 32'h5);
      tick();
      chk("byp_illegal_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("byp_illegal_pending", Pending, 32'd0);

      pw(5'd5, 32'h50, 32'h0, 1'b0);
      ll(5'd10, 32'h100);
      tick();
      chk("enq1_pending", Pending, 32'h0000_0400);
      ll(5'd11, 32'h110);
      tick();
      chk("full_pending", Pending, 32'h0000_0C00);
      chk("full_ll_ready", {31'd0, LL_Ready}, 32'd0);
      ll(5'd13, 32'h130);
      for (int i = 0; i < 2; i++) begin
         pw(5'd5, 32'h51 + i, 32'h0, 1'b0);
         tick();
         chk("starve_no_stall", {31'd0, Stall}, 32'd0);
      end
      tick();
      chk("starve_stall", {31'd0, Stall}, 32'd1);
      chk("held_pending", Pending, 32'h0000_0C00);
      WB_Valid = 0;
      tick();
      chk("stall_waddr", {27'd0, WAddr}, 32'd10);
      chk("stall_wdata", WData, 32'h100);
      chk("stall_ll_ready", {31'd0, LL_Ready}, 32'd1);
      pw(5'd5, 32'h60, 32'h0, 1'b0);
      tick();
      chk("held_enq_pending", Pending, 32'h0000_2800);
      idle();
      tick();
      chk("drain11_waddr", {27'd0, WAddr}, 32'd11);
      tick();
      chk("drain13_wdata", WData, 32'h130);
      chk("drain_pending", Pending, 32'd0);

      pw(5'd5, 32'h70, 32'h0, 1'b0);
      ll(5'd12, 32'h120);
      tick();
      chk("sq_pending_in", Pending, 32'h0000_1000);
      idle();
      pw(5'd12, 32'h55, 32'h0, 1'b0);
      tick();
      chk("sq_waddr", {27'd0, WAddr}, 32'd12);
      chk("sq_wdata", WData, 32'h55);
      chk("sq_pending_out", Pending, 32'd0);
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sq_no_rewrite", {31'd0, RegWrite}, 32'd0);
      end

      pw(5'd14, 32'h14, 32'h0, 1'b0);
      ll(5'd14, 32'hDEAD);
      tick();
      chk("sq_same_cycle_pending", Pending, 32'd0);
      idle();
      tick();
      chk("sq_same_cycle_regwrite", {31'd0, RegWrite}, 32'd0);

      pw(5'd5, 32'h80, 32'h0, 1'b0);
      ll(5'd15, 32'h150);
      tick();
      chk("mid_rst_pending_in", Pending, 32'h0000_8000);
      idle();
      Rst = 1;
      tick();
      Rst = 0;
      chk("mid_rst_pending", Pending, 32'd0);
      chk("mid_rst_wdata", WData, 32'd0);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
